idex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus execute-stage operand selection for the 5-stage MIPS pipeline.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fwd_sel.sv | 27 ++
 rtl/idex_operand_stage.sv | 140 ++++++++++++++
 tb/tb_idex_operand_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared ALU op codes and forward-select encoding
package pipeline_pkg;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - picks the operand source for one execute-stage register specifier
module fwd_sel
  import pipeline_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src,
  input  logic [REGW-1:0] writereg_m,
  input  logic [REGW-1:0] writereg_w,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  output fwd_t            sel
);

  // $0 is hardwired, so a pending write to it must never be forwarded
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (regwrite_m && (writereg_m == src)) begin
        sel = FWD_MEM;
      end else if (regwrite_w && (writereg_w == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/idex_operand_stage.sv
// rtl/idex_operand_stage.sv - ID/EX register, MEM/WB forwarding and ALU operand muxing
module idex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int ALUCW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  rd_d,
  input  logic [ALUCW-1:0] alucontrol_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [REGW-1:0]  writereg_m,
  input  logic             regwrite_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [REGW-1:0]  writereg_w,
  input  logic             regwrite_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [ALUCW-1:0] alucontrol_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [REGW-1:0]  writereg_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             lwstall
);

  logic [WIDTH-1:0] r_rd1_e;
  logic [WIDTH-1:0] r_rd2_e;
  logic [WIDTH-1:0] r_signimm_e;
  logic [REGW-1:0]  r_rs_e;
  logic [REGW-1:0]  r_rt_e;
  logic [REGW-1:0]  r_rd_e;
  logic [ALUCW-1:0] r_alucontrol_e;
  logic             r_alusrc_e;
  logic             r_regdst_e;
  logic             r_regwrite_e;
  logic             r_memtoreg_e;
  logic             r_memwrite_e;

  fwd_t             w_sel_a;
  fwd_t             w_sel_b;
  logic [WIDTH-1:0] w_srca;
  logic [WIDTH-1:0] w_fwd_b;

  // A bubble clears data fields too, so a flushed slot looks identical to reset
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      r_rd1_e        <= '0;
      r_rd2_e        <= '0;
      r_signimm_e    <= '0;
      r_rs_e         <= '0;
      r_rt_e         <= '0;
      r_rd_e         <= '0;
      r_alucontrol_e <= '0;
      r_alusrc_e     <= 1'b0;
      r_regdst_e     <= 1'b0;
      r_regwrite_e   <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_memwrite_e   <= 1'b0;
    end else if (!stall_e) begin
      r_rd1_e        <= rd1_d;
      r_rd2_e        <= rd2_d;
      r_signimm_e    <= signimm_d;
      r_rs_e         <= rs_d;
      r_rt_e         <= rt_d;
      r_rd_e         <= rd_d;
      r_alucontrol_e <= alucontrol_d;
      r_alusrc_e     <= alusrc_d;
      r_regdst_e     <= regdst_d;
      r_regwrite_e   <= regwrite_d;
      r_memtoreg_e   <= memtoreg_d;
      r_memwrite_e   <= memwrite_d;
    end
  end

  fwd_sel #(.REGW(REGW)) u_fwd_a (
    .src        (r_rs_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (w_sel_a)
  );

  fwd_sel #(.REGW(REGW)) u_fwd_b (
    .src        (r_rt_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (w_sel_b)
  );

  always_comb begin
    w_srca = r_rd1_e;
    case (w_sel_a)
      FWD_MEM: w_srca = aluout_m;
      FWD_WB:  w_srca = result_w;
      default: w_srca = r_rd1_e;
    endcase
  end

  always_comb begin
    w_fwd_b = r_rd2_e;
    case (w_sel_b)
      FWD_MEM: w_fwd_b = aluout_m;
      FWD_WB:  w_fwd_b = result_w;
      default: w_fwd_b = r_rd2_e;
    endcase
  end

  assign srca_e       = w_srca;
  assign writedata_e  = w_fwd_b;
  assign srcb_e       = r_alusrc_e ? r_signimm_e : w_fwd_b;
  assign alucontrol_e = r_alucontrol_e;
  assign writereg_e   = r_regdst_e ? r_rd_e : r_rt_e;
  assign regwrite_e   = r_regwrite_e;
  assign memtoreg_e   = r_memtoreg_e;
  assign memwrite_e   = r_memwrite_e;

  // Load in EX whose target is read by the instruction now in decode
  assign lwstall = r_memtoreg_e && (r_rt_e != '0)
                   && ((r_rt_e == rs_d) || (r_rt_e == rt_d));

endmodule

// File: tb/tb_idex_operand_stage.sv
// tb/tb_idex_operand_stage.sv - randomized and directed checks of idex_operand_stage
module tb_idex_operand_stage;
  import pipeline_pkg::*;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  aluc;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
  } instr_t;

  logic        clk;
  logic        reset;
  logic        stall_e;
  logic        flush_e;
  instr_t      d;
  logic [31:0] aluout_m;
  logic [4:0]  writereg_m;
  logic        regwrite_m;
  logic [31:0] result_w;
  logic [4:0]  writereg_w;
  logic        regwrite_w;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] writedata_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e;
  logic        memtoreg_e;
  logic        memwrite_e;
  logic        lwstall;

  int          total = 0;
  int          bad = 0;
  logic        check_en = 1'b0;
  instr_t      m;

  idex_operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall_e      (stall_e),
    .flush_e      (flush_e),
    .rd1_d        (d.rd1),
    .rd2_d        (d.rd2),
    .signimm_d    (d.imm),
    .rs_d         (d.rs),
    .rt_d         (d.rt),
    .rd_d         (d.rd),
    .alucontrol_d (d.aluc),
    .alusrc_d     (d.alusrc),
    .regdst_d     (d.regdst),
    .regwrite_d   (d.regwrite),
    .memtoreg_d   (d.memtoreg),
    .memwrite_d   (d.memwrite),
    .aluout_m     (aluout_m),
    .writereg_m   (writereg_m),
    .regwrite_m   (regwrite_m),
    .result_w     (result_w),
    .writereg_w   (writereg_w),
    .regwrite_w   (regwrite_w),
    .srca_e       (srca_e),
    .srcb_e       (srcb_e),
    .alucontrol_e (alucontrol_e),
    .writedata_e  (writedata_e),
    .writereg_e   (writereg_e),
    .regwrite_e   (regwrite_e),
    .memtoreg_e   (memtoreg_e),
    .memwrite_e   (memwrite_e),
    .lwstall      (lwstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the instruction currently held in EX
  always @(posedge clk) begin
    if (reset || flush_e) m <= '0;
    else if (!stall_e)    m <= d;
  end

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r != 0 && regwrite_m && writereg_m == r) return aluout_m;
    if (r != 0 && regwrite_w && writereg_w == r) return result_w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("srca_e", srca_e, fwd(m.rs, m.rd1));
      chk("writedata_e", writedata_e, fwd(m.rt, m.rd2));
      chk("srcb_e", srcb_e, m.alusrc ? m.imm : fwd(m.rt, m.rd2));
      chk("alucontrol_e", {29'd0, alucontrol_e}, {29'd0, m.aluc});
      chk("writereg_e", {27'd0, writereg_e}, {27'd0, m.regdst ? m.rd : m.rt});
      chk("regwrite_e", {31'd0, regwrite_e}, {31'd0, m.regwrite});
      chk("memtoreg_e", {31'd0, memtoreg_e}, {31'd0, m.memtoreg});
      chk("memwrite_e", {31'd0, memwrite_e}, {31'd0, m.memwrite});
      chk("lwstall", {31'd0, lwstall},
          {31'd0, m.memtoreg && m.rt != 0 && (m.rt == d.rs || m.rt == d.rt)});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_all();
    d.rd1      = $urandom;
    d.rd2      = $urandom;
    d.imm      = $urandom;
    d.rs       = 5'($urandom_range(0, 7));
    d.rt       = 5'($urandom_range(0, 7));
    d.rd       = 5'($urandom_range(0, 7));
    d.aluc     = 3'($urandom);
    d.alusrc   = 1'($urandom);
    d.regdst   = 1'($urandom);
    d.regwrite = 1'($urandom);
    d.memtoreg = 1'($urandom);
    d.memwrite = 1'($urandom);
    aluout_m   = $urandom;
    result_w   = $urandom;
    writereg_m = 5'($urandom_range(0, 7));
    writereg_w = 5'($urandom_range(0, 7));
    regwrite_m = 1'($urandom);
    regwrite_w = 1'($urandom);
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rand_all();
    d.rd1 = 32'hFFFF_FFFF; d.rs = 5'd3; d.rt = 5'd3; d.regwrite = 1'b1; d.memtoreg = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("reset srca_e", srca_e, 32'h0);
    chk("reset srcb_e", srcb_e, 32'h0);
    chk("reset writedata_e", writedata_e, 32'h0);
    chk("reset writereg_e", {27'd0, writereg_e}, 32'h0);
    chk("reset regwrite_e", {31'd0, regwrite_e}, 32'h0);
    chk("reset memtoreg_e", {31'd0, memtoreg_e}, 32'h0);
    chk("reset lwstall", {31'd0, lwstall}, 32'h0);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    // add $3,$1,$2
    d = '0;
    d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3; d.rd1 = 32'd5; d.rd2 = 32'd7;
    d.aluc = ALUCTL_ADD; d.regdst = 1'b1; d.regwrite = 1'b1;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    step();
    @(negedge clk);
    chk("add srca_e", srca_e, 32'd5);
    chk("add srcb_e", srcb_e, 32'd7);
    chk("add writereg_e", {27'd0, writereg_e}, 32'd3);
    chk("add regwrite_e", {31'd0, regwrite_e}, 32'd1);
    chk("add alucontrol_e", {29'd0, alucontrol_e}, 32'd2);

    // MEM beats WB for rs=4
    #1;
    d = '0; d.rs = 5'd4; d.rt = 5'd5; d.rd1 = 32'h99; d.rd2 = 32'h98;
    step();
    stall_e = 1'b1;
    regwrite_m = 1'b1; writereg_m = 5'd4; aluout_m = 32'h11;
    regwrite_w = 1'b1; writereg_w = 5'd4; result_w = 32'h22;
    @(negedge clk);
    chk("fwd mem srca_e", srca_e, 32'h11);
    #1;
    regwrite_m = 1'b0;
    #1;
    chk("fwd wb srca_e", srca_e, 32'h22);
    stall_e = 1'b0; regwrite_w = 1'b0;

    // $0 never forwarded
    d = '0; d.rt = 5'd0; d.rd2 = 32'h1234;
    step();
    regwrite_m = 1'b1; writereg_m = 5'd0; aluout_m = 32'hDEAD;
    @(negedge clk);
    chk("r0 srcb_e", srcb_e, 32'h1234);
    chk("r0 writedata_e", writedata_e, 32'h1234);
    #1;
    regwrite_m = 1'b0;

    // load-use then stall+flush bubble
    d = '0; d.rt = 5'd8; d.memtoreg = 1'b1; d.regwrite = 1'b1;
    step();
    d.rs = 5'd8; d.rt = 5'd3;
    @(negedge clk);
    chk("loaduse lwstall", {31'd0, lwstall}, 32'd1);
    #1;
    stall_e = 1'b1; flush_e = 1'b1;
    step();
    stall_e = 1'b0; flush_e = 1'b0;
    @(negedge clk);
    chk("bubble regwrite_e", {31'd0, regwrite_e}, 32'd0);
    chk("bubble memwrite_e", {31'd0, memwrite_e}, 32'd0);
    chk("bubble lwstall", {31'd0, lwstall}, 32'd0);
    #1;

    // stall holds across changing decode inputs
    d = '0; d.rs = 5'd6; d.rt = 5'd7; d.rd = 5'd9; d.rd1 = 32'h100; d.rd2 = 32'h200;
    d.aluc = ALUCTL_SUB; d.regdst = 1'b1; d.regwrite = 1'b1;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    step();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      rand_all();
      regwrite_m = 1'b0; regwrite_w = 1'b0;
      @(negedge clk);
      chk("stall srca_e", srca_e, 32'h100);
      chk("stall writereg_e", {27'd0, writereg_e}, 32'd9);
      chk("stall alucontrol_e", {29'd0, alucontrol_e}, 32'd6);
    end
    #1;
    regwrite_m = 1'b1; writereg_m = 5'd6; aluout_m = 32'hABC;
    #1;
    chk("stall fwd srca_e", srca_e, 32'hABC);
    stall_e = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step();
      rand_all();
      reset   = ($urandom_range(0, 49) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
    end
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
